// File: rtl/data_cache_burst_fsm.sv
// Data cache controller FSM: tag check, dirty-victim write-back with B-response retry,
// and beat-counted line fill over an AXI-style burst interface.
module data_cache_burst_fsm #(
    parameter int unsigned BLOCK_WORDS     = 16,
    parameter bit          WB_ON_READ_MISS = 1'b1,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           i_start_check,
    input  logic                           i_write,
    input  logic                           i_hit,
    input  logic                           i_dirty,
    input  logic                           i_ar_ready,
    input  logic                           i_r_valid,
    input  logic                           i_r_last,
    input  logic                           i_aw_ready,
    input  logic                           i_w_ready,
    input  logic                           i_b_valid,
    input  logic [1:0]                     i_b_resp,
    input  logic                           i_err_clear,
    output logic                           o_stall,
    output logic                           o_data_block_write_en,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
    output logic                           o_valid_update,
    output logic                           o_dirty_set,
    output logic                           o_dirty_clear,
    output logic                           o_lru_update,
    output logic                           o_ar_valid,
    output logic                           o_aw_valid,
    output logic                           o_w_valid,
    output logic                           o_w_last,
    output logic                           o_addr_control,
    output logic                           o_bus_error
);

    localparam int unsigned CW = $clog2(BLOCK_WORDS);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(BLOCK_WORDS - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE_TAG,
        WB_ADDR,
        WB_DATA,
        WB_RESP,
        AL_ADDR,
        AL_DATA
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;
    logic          err_set;

    // State, beat counter, retry counter and sticky error
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake outputs; bus valids decode straight from state so reset drops them at once
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        retry_d               = retry_q;
        err_set               = 1'b0;
        o_stall               = 1'b1;
        o_addr_control        = 1'b1;
        o_data_block_write_en = 1'b0;
        o_word_idx            = '0;
        o_valid_update        = 1'b0;
        o_dirty_set           = 1'b0;
        o_dirty_clear         = 1'b0;
        o_lru_update          = 1'b0;
        o_ar_valid            = 1'b0;
        o_aw_valid            = 1'b0;
        o_w_valid             = 1'b0;
        o_w_last              = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start_check) begin
                    state_d = COMPARE_TAG;
                end
            end
            COMPARE_TAG: begin
                if (i_hit) begin
                    o_stall      = 1'b0;
                    o_lru_update = 1'b1;
                    o_dirty_set  = i_write;
                    state_d      = IDLE;
                end else if (i_dirty && (i_write || WB_ON_READ_MISS)) begin
                    retry_d = '0;
                    state_d = WB_ADDR;
                end else begin
                    state_d = AL_ADDR;
                end
            end
            WB_ADDR: begin
                o_aw_valid     = 1'b1;
                o_addr_control = 1'b0;
                if (i_aw_ready) begin
                    cnt_d   = '0;
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                o_w_valid      = 1'b1;
                o_addr_control = 1'b0;
                o_word_idx     = cnt_q;
                o_w_last       = (cnt_q == LAST_IDX);
                if (i_w_ready) begin
                    cnt_d = CW'(cnt_q + 1'b1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = WB_RESP;
                    end
                end
            end
            WB_RESP: begin
                o_addr_control = 1'b0;
                if (i_b_valid) begin
                    if (i_b_resp == 2'b00) begin
                        o_dirty_clear = 1'b1;
                        state_d       = AL_ADDR;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = RW'(retry_q + 1'b1);
                        state_d = WB_ADDR;
                    end else begin
                        // Retries exhausted: the victim line is dropped and the fill proceeds
                        err_set = 1'b1;
                        state_d = AL_ADDR;
                    end
                end
            end
            AL_ADDR: begin
                o_ar_valid = 1'b1;
                if (i_ar_ready) begin
                    cnt_d   = '0;
                    state_d = AL_DATA;
                end
            end
            AL_DATA: begin
                o_word_idx = cnt_q;
                if (i_r_valid) begin
                    o_data_block_write_en = 1'b1;
                    cnt_d                 = CW'(cnt_q + 1'b1);
                    if (i_r_last != (cnt_q == LAST_IDX)) begin
                        err_set = 1'b1;
                    end
                    // Completion follows the local beat count, not the bus last flag
                    if (cnt_q == LAST_IDX) begin
                        o_valid_update = 1'b1;
                        o_dirty_clear  = 1'b1;
                        state_d        = COMPARE_TAG;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = err_set ? 1'b1 : (i_err_clear ? 1'b0 : err_q);
    end

    assign o_bus_error = err_q;

endmodule

// File: tb/tb_data_cache_burst_fsm.sv
// Bench for data_cache_burst_fsm: a transaction-level driver predicts every output per cycle
// while driving randomized handshake timing; a compare thread checks on each falling edge.
module tb_data_cache_burst_fsm;

    localparam int BW   = 4;
    localparam int MR   = 3;
    localparam bit WBRM = 1'b1;

    logic       clk;
    logic       arstn;
    logic       i_start_check, i_write, i_hit, i_dirty;
    logic       i_ar_ready, i_r_valid, i_r_last, i_aw_ready, i_w_ready, i_b_valid;
    logic [1:0] i_b_resp;
    logic       i_err_clear;
    logic       o_stall, o_data_block_write_en, o_valid_update, o_dirty_set, o_dirty_clear;
    logic       o_lru_update, o_ar_valid, o_aw_valid, o_w_valid, o_w_last, o_addr_control;
    logic       o_bus_error;
    logic [1:0] o_word_idx;

    // expected outputs for the current cycle
    logic       e_stall, e_dwe, e_vupd, e_dset, e_dclr, e_lru, e_ar, e_aw, e_w, e_wlast, e_addrc, e_err;
    logic [1:0] e_idx;

    int n_checks;
    int n_errors;
    int ar_hs, aw_hs, dwe_n, vupd_n;
    bit err_model;
    bit pend_set;
    bit rand_clr;

    data_cache_burst_fsm #(
        .BLOCK_WORDS    (BW),
        .WB_ON_READ_MISS(WBRM),
        .MAX_RETRY      (MR)
    ) dut (
        .clk                  (clk),
        .arstn                (arstn),
        .i_start_check        (i_start_check),
        .i_write              (i_write),
        .i_hit                (i_hit),
        .i_dirty              (i_dirty),
        .i_ar_ready           (i_ar_ready),
        .i_r_valid            (i_r_valid),
        .i_r_last             (i_r_last),
        .i_aw_ready           (i_aw_ready),
        .i_w_ready            (i_w_ready),
        .i_b_valid            (i_b_valid),
        .i_b_resp             (i_b_resp),
        .i_err_clear          (i_err_clear),
        .o_stall              (o_stall),
        .o_data_block_write_en(o_data_block_write_en),
        .o_word_idx           (o_word_idx),
        .o_valid_update       (o_valid_update),
        .o_dirty_set          (o_dirty_set),
        .o_dirty_clear        (o_dirty_clear),
        .o_lru_update         (o_lru_update),
        .o_ar_valid           (o_ar_valid),
        .o_aw_valid           (o_aw_valid),
        .o_w_valid            (o_w_valid),
        .o_w_last             (o_w_last),
        .o_addr_control       (o_addr_control),
        .o_bus_error          (o_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int ex);
        n_checks++;
        if (act != ex) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic int pick(input int dly);
        return (dly < 0) ? int'($urandom_range(2, 0)) : dly;
    endfunction

    task automatic set_exp_idle();
        e_stall = 1'b1; e_addrc = 1'b1; e_dwe = 1'b0; e_vupd = 1'b0; e_dset = 1'b0;
        e_dclr  = 1'b0; e_lru   = 1'b0; e_ar  = 1'b0; e_aw   = 1'b0; e_w    = 1'b0;
        e_wlast = 1'b0; e_idx   = 2'd0; e_err = err_model;
    endtask

    // Advance to just after the next rising edge; ignored inputs get random noise
    task automatic step(input bit busy);
        @(posedge clk);
        #1;
        if (pend_set) err_model = 1'b1;
        else if (i_err_clear) err_model = 1'b0;
        pend_set      = 1'b0;
        i_start_check = busy ? 1'($urandom_range(1, 0)) : 1'b0;
        i_write       = 1'($urandom_range(1, 0));
        i_hit         = 1'($urandom_range(1, 0));
        i_dirty       = 1'($urandom_range(1, 0));
        i_ar_ready    = 1'($urandom_range(1, 0));
        i_r_valid     = 1'($urandom_range(1, 0));
        i_r_last      = 1'($urandom_range(1, 0));
        i_aw_ready    = 1'($urandom_range(1, 0));
        i_w_ready     = 1'($urandom_range(1, 0));
        i_b_valid     = 1'($urandom_range(1, 0));
        i_b_resp      = 2'($urandom_range(3, 0));
        i_err_clear   = rand_clr ? ($urandom_range(7, 0) == 0) : 1'b0;
        set_exp_idle();
    endtask

    task automatic w_exp(input int k);
        e_w = 1'b1; e_addrc = 1'b0; e_idx = 2'(k); e_wlast = (k == BW - 1);
    endtask

    // One LSU access from request to completion, predicting outputs beat by beat
    task automatic acc(input bit wr, input bit hit, input bit dirty, input int nerr, input int bad_rl,
                       input int wsb, input int wsl, input int rgap, input int dly);
        int d;
        bit wb;
        d = pick(dly);
        repeat (d) step(0);
        step(0); i_start_check = 1'b1;
        step(1); i_hit = hit; i_dirty = dirty; i_write = wr;
        if (hit) begin
            e_stall = 1'b0; e_lru = 1'b1; e_dset = wr;
            return;
        end
        wb = dirty && (wr || WBRM);
        if (wb) begin
            for (int a = 0; a <= MR; a++) begin
                d = pick(dly);
                repeat (d) begin step(1); i_aw_ready = 1'b0; e_aw = 1'b1; e_addrc = 1'b0; end
                step(1); i_aw_ready = 1'b1; e_aw = 1'b1; e_addrc = 1'b0;
                for (int k = 0; k < BW; k++) begin
                    d = (k == wsb) ? wsl : ((dly < 0) ? int'($urandom_range(1, 0)) : 0);
                    repeat (d) begin step(1); i_w_ready = 1'b0; w_exp(k); end
                    step(1); i_w_ready = 1'b1; w_exp(k);
                end
                d = pick(dly);
                repeat (d) begin step(1); i_b_valid = 1'b0; e_addrc = 1'b0; end
                step(1); i_b_valid = 1'b1; e_addrc = 1'b0;
                if (a >= nerr) begin
                    i_b_resp = 2'b00; e_dclr = 1'b1;
                    break;
                end
                i_b_resp = 2'($urandom_range(3, 1));
                if (a == MR) begin
                    pend_set = 1'b1;
                    break;
                end
            end
        end
        d = pick(dly);
        repeat (d) begin step(1); i_ar_ready = 1'b0; e_ar = 1'b1; end
        step(1); i_ar_ready = 1'b1; e_ar = 1'b1;
        for (int k = 0; k < BW; k++) begin
            d = (rgap < 0) ? int'($urandom_range(2, 0)) : rgap;
            repeat (d) begin step(1); i_r_valid = 1'b0; e_idx = 2'(k); end
            step(1);
            i_r_valid = 1'b1;
            i_r_last  = (bad_rl >= 0) ? (k == bad_rl) : (k == BW - 1);
            e_dwe = 1'b1; e_idx = 2'(k);
            if (i_r_last != (k == BW - 1)) pend_set = 1'b1;
            if (k == BW - 1) begin e_vupd = 1'b1; e_dclr = 1'b1; end
        end
        step(1); i_hit = 1'b1; i_write = wr;
        e_stall = 1'b0; e_lru = 1'b1; e_dset = wr;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin : main
        int a0, r0, d0, v0;
        n_checks = 0; n_errors = 0;
        ar_hs = 0; aw_hs = 0; dwe_n = 0; vupd_n = 0;
        err_model = 1'b0; pend_set = 1'b0; rand_clr = 1'b0;
        arstn = 1'b0;
        i_start_check = 0; i_write = 0; i_hit = 0; i_dirty = 0; i_ar_ready = 0; i_r_valid = 0;
        i_r_last = 0; i_aw_ready = 0; i_w_ready = 0; i_b_valid = 0; i_b_resp = 2'b00; i_err_clear = 0;
        set_exp_idle();

        fork
            forever begin
                @(negedge clk);
                chk("stall", o_stall, e_stall);
                chk("addr_control", o_addr_control, e_addrc);
                chk("data_write_en", o_data_block_write_en, e_dwe);
                chk("word_idx", o_word_idx, e_idx);
                chk("valid_update", o_valid_update, e_vupd);
                chk("dirty_set", o_dirty_set, e_dset);
                chk("dirty_clear", o_dirty_clear, e_dclr);
                chk("lru_update", o_lru_update, e_lru);
                chk("ar_valid", o_ar_valid, e_ar);
                chk("aw_valid", o_aw_valid, e_aw);
                chk("w_valid", o_w_valid, e_w);
                chk("w_last", o_w_last, e_wlast);
                chk("bus_error", o_bus_error, e_err);
                if (o_ar_valid && i_ar_ready) ar_hs++;
                if (o_aw_valid && i_aw_ready) aw_hs++;
                if (o_data_block_write_en) dwe_n++;
                if (o_valid_update) vupd_n++;
            end
        join_none

        // reset state
        repeat (3) step(0);
        #1;
        chk("rst_stall_lit", o_stall, 1);
        chk("rst_addr_ctl_lit", o_addr_control, 1);
        chk("rst_err_lit", o_bus_error, 0);
        arstn = 1'b1;

        // read hit: released in the second cycle
        acc(0, 1, 0, 0, -1, -1, 0, 0, 0);
        #1;
        chk("hit_stall_lit", o_stall, 0);
        chk("hit_lru_lit", o_lru_update, 1);

        // clean read miss, r_valid every other cycle
        a0 = ar_hs; d0 = dwe_n; v0 = vupd_n; r0 = aw_hs;
        acc(0, 0, 0, 0, -1, -1, 0, 1, 0);
        @(negedge clk); #1;
        chk("clean_ar_count", ar_hs - a0, 1);
        chk("clean_aw_count", aw_hs - r0, 0);
        chk("clean_beats", dwe_n - d0, 4);
        chk("clean_vupd", vupd_n - v0, 1);

        // dirty write miss, W stalled 2 cycles on beat 1
        a0 = ar_hs; r0 = aw_hs; d0 = dwe_n;
        acc(1, 0, 1, 0, -1, 1, 2, 0, 1);
        @(negedge clk); #1;
        chk("dirty_aw_count", aw_hs - r0, 1);
        chk("dirty_ar_count", ar_hs - a0, 1);
        chk("dirty_beats", dwe_n - d0, 4);

        // three error responses are absorbed by retries
        r0 = aw_hs;
        acc(1, 0, 1, 3, -1, -1, 0, 0, 0);
        @(negedge clk); #1;
        chk("retry3_aw_count", aw_hs - r0, 4);
        chk("retry3_err_lit", o_bus_error, 0);

        // fourth error gives up and raises the sticky flag
        r0 = aw_hs;
        acc(1, 0, 1, 4, -1, -1, 0, 0, 0);
        @(negedge clk); #1;
        chk("retry4_aw_count", aw_hs - r0, 4);
        chk("retry4_err_lit", o_bus_error, 1);
        repeat (3) step(0);
        chk("err_sticky_lit", o_bus_error, 1);
        step(0); i_err_clear = 1'b1;
        step(0);
        chk("err_cleared_lit", o_bus_error, 0);

        // early r_last on beat 2: error, but fill still completes on beat 3
        d0 = dwe_n; v0 = vupd_n;
        acc(0, 0, 0, 0, 2, -1, 0, 0, 0);
        @(negedge clk); #1;
        chk("rlast_err_lit", o_bus_error, 1);
        chk("rlast_beats", dwe_n - d0, 4);
        chk("rlast_vupd", vupd_n - v0, 1);
        step(0); i_err_clear = 1'b1;

        // reset in the middle of the write-back burst
        step(0); i_start_check = 1'b1;
        step(1); i_hit = 1'b0; i_dirty = 1'b1; i_write = 1'b1;
        step(1); i_aw_ready = 1'b1; e_aw = 1'b1; e_addrc = 1'b0;
        step(1); i_w_ready = 1'b1; w_exp(0);
        step(1); i_w_ready = 1'b0; i_err_clear = 1'b0;
        #1;
        chk("pre_rst_w_valid", o_w_valid, 1);
        chk("pre_rst_idx", o_word_idx, 1);
        arstn = 1'b0; err_model = 1'b0; pend_set = 1'b0; e_err = 1'b0;
        #1;
        chk("rst_w_valid", o_w_valid, 0);
        chk("rst_aw_valid", o_aw_valid, 0);
        chk("rst_stall", o_stall, 1);
        step(0);
        step(0); arstn = 1'b1;
        acc(1, 0, 1, 0, -1, -1, 0, 0, 0);

        // randomized traffic
        rand_clr = 1'b1;
        repeat (150) begin
            acc(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 1)) : 0,
                ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                -1, 0, -1, -1);
        end
        rand_clr = 1'b0;
        repeat (3) step(0);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
